wave_scheduler: RTL
===================

WAVE_SCHEDULER -- requirements
Module: wave_scheduler

Interface
REQ-001 The block SHALL have parameter ENEMY_COUNT, default 23, number of enemy slots.
REQ-002 The block SHALL have parameter GROUP_COUNT, default 3, number of spawn groups.
REQ-003 The block SHALL have parameter TICK_DIV, default 25_000_000, clk25 cycles per timer tick (1 s).
REQ-004 The block SHALL have parameter GROUP_MASKS, default {23'h600000, 23'h1E0000, 23'h01FFFF}, flattened GROUP_COUNT*ENEMY_COUNT; group g occupies bits [g*ENEMY_COUNT +: ENEMY_COUNT].
REQ-005 The block SHALL have parameter GROUP_DELAY, default {8'd10, 8'd10, 8'd0}, flattened GROUP_COUNT*8; ticks from previous spawn (group 0: from start) to group g spawn.
REQ-006 The block SHALL have port clk25, input, 1, sole clock.
REQ-007 The block SHALL have port global_reset_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1, pulse; begins a stage from IDLE or DONE.
REQ-009 The block SHALL have port pause, input, 1, level; freezes prescaler and delay counter.
REQ-010 The block SHALL have port mode, input, 1; 0 = timed, 1 = clear-advance; sampled on accepted start.
REQ-011 The block SHALL have port enemy_alive_out, input, ENEMY_COUNT, live flags from enemy controller.
REQ-012 The block SHALL have port enemy_alive_in, output, ENEMY_COUNT, registered live flags to enemy controller.
REQ-013 The block SHALL have port group_reset, output, GROUP_COUNT, one-cycle pulse on bit g when group g spawns.
REQ-014 The block SHALL have port group_idx, output, $clog2(GROUP_COUNT+1), index of next group to spawn (GROUP_COUNT once all are spawned).
REQ-015 The block SHALL have ports wave_clear (output, 1, pulse), stage_done (output, 1, level) and round (output, 4, completed-stage count).

Function
REQ-016 States SHALL be IDLE, WAIT, SPAWN, LAST, DONE.
REQ-017 IDLE/DONE + start SHALL go to WAIT with group_idx=0, counters cleared, spawned_mask=0, stage_done=0, mode latched; start in other states SHALL be ignored.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 when pause=0, emitting tick on the wrap cycle; the delay counter SHALL increment on tick, saturate at 255, and hold while pause=1.
REQ-019 WAIT SHALL go to SPAWN when delay counter >= GROUP_DELAY[group_idx] (delay 0 spawns on the next cycle); in mode 1 it SHALL also go to SPAWN when (enemy_alive_out & spawned_mask)==0 and spawned_mask!=0, whichever comes first.
REQ-020 SPAWN SHALL last exactly one cycle: enemy_alive_in <= enemy_alive_out | mask[g], group_reset[g]=1, spawned_mask |= mask[g], delay counter and prescaler cleared, group_idx+1; next state WAIT, or LAST if g was GROUP_COUNT-1.
REQ-021 Outside SPAWN, enemy_alive_in SHALL equal enemy_alive_out registered (1-cycle latency).
REQ-022 Spawn and kill of the same bit in the same cycle SHALL resolve to alive (OR wins).
REQ-023 wave_clear SHALL pulse one cycle when (enemy_alive_out & spawned_mask) goes from nonzero to zero while spawned_mask != 0, in any state.
REQ-024 LAST SHALL go to DONE when (enemy_alive_out & spawned_mask)==0; on entry, stage_done=1 and round increments, wrapping 15->0.
REQ-025 Pause SHALL NOT block pass-through, clear detection or the LAST->DONE transition.

Reset
REQ-026 global_reset_n=0 SHALL asynchronously force state IDLE and zero on all outputs, counters, spawned_mask and latched mode; operation SHALL resume only on a start after release, including after a reset mid-stage.

Verification (TICK_DIV=4, default masks/delays, except where noted)
REQ-027 Timed: start, mode=0, no kills -> group_reset=001 one cycle after start, 010 after 40 more cycles, 100 after 40 more; enemy_alive_in=23'h7FFFFF; group_idx=3.
REQ-028 Clear-advance: mode=1, clear bits 0..16 at 8 cycles after spawn -> wave_clear pulse, group 1 spawns next cycle (before 40-cycle timeout).
REQ-029 Pause: hold pause 20 cycles during WAIT of group 1 -> group 1 spawns 60 cycles after group 0.
REQ-030 Spawn collision: enemy_alive_out bit 17 toggles in the group-1 SPAWN cycle -> enemy_alive_in bit 17 = 1.
REQ-031 Completion: all groups spawned, then alive cleared -> stage_done=1, round 0->1; second start restarts at group 0; 16 stages -> round wraps to 0.
REQ-032 Reset mid-WAIT of group 2 -> all outputs 0 immediately; no group_reset until a new start.

Source files
------------

// File: rtl/wave_scheduler.sv
// Stage spawn sequencer: releases enemy groups on tick-based delays or, in
// clear-advance mode, as soon as every spawned enemy is dead.
module wave_scheduler #(
   parameter int ENEMY_COUNT = 23,
   parameter int GROUP_COUNT = 3,
   parameter int TICK_DIV    = 25_000_000,
   parameter logic [GROUP_COUNT*ENEMY_COUNT-1:0] GROUP_MASKS = {23'h600000, 23'h1E0000, 23'h01FFFF},
   parameter logic [GROUP_COUNT*8-1:0]           GROUP_DELAY = {8'd10, 8'd10, 8'd0}
) (
   input  logic                               clk25,
   input  logic                               global_reset_n,
   input  logic                               start,
   input  logic                               pause,
   input  logic                               mode,
   input  logic [ENEMY_COUNT-1:0]             enemy_alive_out,
   output logic [ENEMY_COUNT-1:0]             enemy_alive_in,
   output logic [GROUP_COUNT-1:0]             group_reset,
   output logic [$clog2(GROUP_COUNT+1)-1:0]   group_idx,
   output logic                               wave_clear,
   output logic                               stage_done,
   output logic [3:0]                         round
);

   localparam int IDX_W = $clog2(GROUP_COUNT + 1);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, WAIT, SPAWN, LAST, DONE} state_t;

   state_t                 state, state_nxt;
   logic [PRE_W-1:0]       presc;
   logic [7:0]             dcnt;
   logic [7:0]             dcnt_nxt;
   logic [ENEMY_COUNT-1:0] spawned_mask;
   logic [ENEMY_COUNT-1:0] live;
   logic                   live_any;
   logic                   live_prev;
   logic                   mode_q;
   logic                   tick;
   logic                   delay_hit;
   logic                   clear_hit;
   logic                   start_ok;
   logic                   spawn_go;

   function automatic logic [ENEMY_COUNT-1:0] mask_of(input logic [IDX_W-1:0] g);
      mask_of = '0;
      for (int i = 0; i < GROUP_COUNT; i++)
         if (g == IDX_W'(i)) mask_of = GROUP_MASKS[i*ENEMY_COUNT +: ENEMY_COUNT];
   endfunction

   function automatic logic [7:0] delay_of(input logic [IDX_W-1:0] g);
      delay_of = '0;
      for (int i = 0; i < GROUP_COUNT; i++)
         if (g == IDX_W'(i)) delay_of = GROUP_DELAY[i*8 +: 8];
   endfunction

   assign live      = enemy_alive_out & spawned_mask;
   assign live_any  = |live;
   assign tick      = !pause && (presc == PRE_W'(TICK_DIV - 1));
   assign dcnt_nxt  = (tick && dcnt != 8'hFF) ? dcnt + 8'd1 : dcnt;
   // Look ahead by one tick so a delay of N ticks spans exactly N*TICK_DIV cycles spawn-to-spawn
   assign delay_hit = dcnt_nxt >= delay_of(group_idx);
   assign clear_hit = mode_q && (spawned_mask != '0) && !live_any;

   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      spawn_go  = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = WAIT;
               start_ok  = 1'b1;
            end
         end
         WAIT: begin
            if (delay_hit || clear_hit) begin
               state_nxt = SPAWN;
               spawn_go  = 1'b1;
            end
         end
         SPAWN: state_nxt = (group_idx == IDX_W'(GROUP_COUNT - 1)) ? LAST : WAIT;
         LAST:  if (!live_any) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      group_reset = '0;
      for (int i = 0; i < GROUP_COUNT; i++)
         if (state == SPAWN && group_idx == IDX_W'(i)) group_reset[i] = 1'b1;
   end

   always_ff @(posedge clk25 or negedge global_reset_n) begin
      if (!global_reset_n) begin
         state          <= IDLE;
         presc          <= '0;
         dcnt           <= '0;
         spawned_mask   <= '0;
         live_prev      <= 1'b0;
         mode_q         <= 1'b0;
         enemy_alive_in <= '0;
         group_idx      <= '0;
         wave_clear     <= 1'b0;
         stage_done     <= 1'b0;
         round          <= '0;
      end else begin
         state      <= state_nxt;
         live_prev  <= live_any;
         wave_clear <= live_prev && !live_any && (spawned_mask != '0);

         // Spawned bits are ORed in, so a same-cycle kill cannot win
         if (state == SPAWN)
            enemy_alive_in <= enemy_alive_out | mask_of(group_idx);
         else
            enemy_alive_in <= enemy_alive_out;

         if (start_ok || spawn_go) begin
            presc <= '0;
            dcnt  <= '0;
         end else if (!pause) begin
            presc <= tick ? '0 : presc + PRE_W'(1);
            dcnt  <= dcnt_nxt;
         end

         if (start_ok) begin
            group_idx    <= '0;
            spawned_mask <= '0;
            stage_done   <= 1'b0;
            mode_q       <= mode;
         end

         if (state == SPAWN) begin
            spawned_mask <= spawned_mask | mask_of(group_idx);
            group_idx    <= group_idx + IDX_W'(1);
         end

         if (state == LAST && state_nxt == DONE) begin
            stage_done <= 1'b1;
            round      <= round + 4'd1;
         end
      end
   end

endmodule
